// File: rtl/dma_src_mem_pkg.sv
// Shared types and constants for the DMA source memory and its DMA master.
package dma_src_mem_pkg;

  localparam logic [31:0] DMA_SRC_BASE_ADDR  = 32'h3800_0000;
  localparam int          DMA_SRC_READ_DELAY = 4;
  localparam int          DMA_SRC_WORDS_LOG2 = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_ACK  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_ACK  = 2'd3
  } src_state_e;

  // word_addr is sized for the widest supported window plus the
  // one-past-the-end bit used by the stream address.
  typedef struct packed {
    logic        valid;
    logic        is_pf;
    logic [15:0] word_addr;
    logic [31:0] data;
  } pipe_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dma_src_mem_pf_fifo.sv
// Prefetch data FIFO: DEPTH entries, simultaneous push/pop, flush wins.
module dma_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Data storage; contents are meaningless while the entry is not counted.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dma_src_mem.sv
// Wishbone slave RAM with a slow pipelined read path and a sequential
// stream prefetcher that hides the read delay from the DMA master.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | only state that samples a request
// ST_WR_ACK  | write landed, ack is high
// ST_RD_WAIT | waiting for a demand read or an in-flight prefetch
// ST_RD_ACK  | read data on the bus, ack is high
module dma_src_mem
  import dma_src_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DMA_SRC_BASE_ADDR,
  parameter int          WORDS_LOG2 = DMA_SRC_WORDS_LOG2,
  parameter int          READ_DELAY = DMA_SRC_READ_DELAY,
  parameter int          PF_DEPTH   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] pf_hits_o
);

  localparam int AW   = WORDS_LOG2;
  localparam int SW   = WORDS_LOG2 + 1;       // MSB set = past the window end
  // The ack/dat register (demand) or the FIFO push (prefetch) is the final
  // delay stage, so READ_DELAY-1 pipeline registers give READ_DELAY total.
  localparam int NSTG = READ_DELAY - 1;
  localparam int CW   = $clog2(PF_DEPTH + 1);
  localparam int IW   = $clog2(NSTG + 1);

  src_state_e  state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] hits_q, hits_d;
  logic        stream_q, stream_d;
  logic [SW-1:0] exp_q, exp_d;
  logic [SW-1:0] iss_q, iss_d;
  pipe_entry_t pipe_q [NSTG];
  pipe_entry_t pipe_in;

  logic [31:0] mem_q [2**AW];

  logic          req;
  logic [AW-1:0] req_waddr;
  logic [SW-1:0] req_saddr;
  logic          mem_we, flush, demand, pf_issue, pf_pending;
  logic          fifo_pop, fifo_push, fifo_empty;
  logic [31:0]   fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic [IW-1:0] inflight;
  logic [15:0]   occupancy;
  logic [1:0]    unused_adr;

  assign req       = wbs_stb_i && wbs_cyc_i &&
                     (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign req_waddr = wbs_adr_i[AW+1:2];
  assign req_saddr = {1'b0, req_waddr};
  assign unused_adr = wbs_adr_i[1:0];

  assign fifo_push = pipe_q[NSTG-1].valid && pipe_q[NSTG-1].is_pf;
  assign occupancy = 16'(fifo_cnt) + 16'(inflight);

  // Count in-flight prefetches and look for the one the stream expects next.
  always_comb begin
    inflight   = '0;
    pf_pending = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      if (pipe_q[i].valid && pipe_q[i].is_pf) begin
        inflight = inflight + IW'(1);
        if (pipe_q[i].word_addr == 16'(exp_q)) pf_pending = 1'b1;
      end
    end
  end

  // FSM next state, ack/data, stream bookkeeping and pipeline issue.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_d    = '0;
    hits_d   = hits_q;
    stream_d = stream_q;
    exp_d    = exp_q;
    iss_d    = iss_q;
    mem_we   = 1'b0;
    flush    = 1'b0;
    demand   = 1'b0;
    fifo_pop = 1'b0;
    pf_issue = 1'b0;
    pipe_in  = '0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (wbs_we_i) begin
            mem_we   = 1'b1;
            flush    = 1'b1;
            stream_d = 1'b0;
            ack_d    = 1'b1;
            state_d  = ST_WR_ACK;
          end else if (stream_q && (req_saddr == exp_q) && !fifo_empty) begin
            fifo_pop = 1'b1;
            ack_d    = 1'b1;
            dat_d    = fifo_dout;
            hits_d   = sat_inc16(hits_q);
            exp_d    = exp_q + SW'(1);
            state_d  = ST_RD_ACK;
          end else if (stream_q && (req_saddr == exp_q) && pf_pending) begin
            hits_d   = sat_inc16(hits_q);
            exp_d    = exp_q + SW'(1);
            state_d  = ST_RD_WAIT;
          end else begin
            flush    = 1'b1;
            demand   = 1'b1;
            stream_d = 1'b1;
            exp_d    = req_saddr + SW'(1);
            iss_d    = req_saddr + SW'(1);
            state_d  = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // Only one of these can be outstanding: a miss flushed all prefetches.
        if (pipe_q[NSTG-1].valid && !pipe_q[NSTG-1].is_pf) begin
          ack_d   = 1'b1;
          dat_d   = pipe_q[NSTG-1].data;
          state_d = ST_RD_ACK;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          ack_d    = 1'b1;
          dat_d    = fifo_dout;
          state_d  = ST_RD_ACK;
        end
      end
      ST_WR_ACK, ST_RD_ACK: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase

    pf_issue = stream_q && !iss_q[SW-1] && (occupancy < 16'(PF_DEPTH)) &&
               !demand && !flush;
    if (pf_issue) iss_d = iss_q + SW'(1);

    if (demand) begin
      pipe_in.valid     = 1'b1;
      pipe_in.is_pf     = 1'b0;
      pipe_in.word_addr = 16'(req_saddr);
      pipe_in.data      = mem_q[req_waddr];
    end else if (pf_issue) begin
      pipe_in.valid     = 1'b1;
      pipe_in.is_pf     = 1'b1;
      pipe_in.word_addr = 16'(iss_q);
      pipe_in.data      = mem_q[iss_q[AW-1:0]];
    end
  end

  // Control and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      hits_q   <= '0;
      stream_q <= 1'b0;
      exp_q    <= '0;
      iss_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      hits_q   <= hits_d;
      stream_q <= stream_d;
      exp_q    <= exp_d;
      iss_q    <= iss_d;
    end
  end

  // Read pipeline; a flush kills everything already in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NSTG; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < NSTG; i++) pipe_q[i] <= flush ? '0 : pipe_q[i-1];
    end
  end

  // Backing RAM byte-enabled write; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) mem_q[req_waddr][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  dma_pf_fifo #(
    .DEPTH (PF_DEPTH),
    .W     (32),
    .CW    (CW)
  ) u_pf_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (fifo_push),
    .din_i   (pipe_q[NSTG-1].data),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign pf_hits_o = hits_q;

endmodule
